// File: rtl/dense_layer_2.sv
// dense_layer_2 -- second fully-connected layer of the speech-recognition net.
//
//   output_vector[j] = sat48(bias_vector[j] + sum_i weight_matrix[j*IN_SIZE_2+i] * input_vector[i])
//
// A single signed MAC sweeps every neuron in turn and never stops: IN_SIZE_2
// accumulate cycles are followed by one WRITE cycle per neuron. After the last
// neuron it wraps to neuron 0. There is no start/done handshake; the
// outputs converge within two passes of the inputs becoming stable.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low (0 = reset asserted)
//   input_vector   IN_SIZE_2 x signed 32-bit layer input, held stable while in use
//   output_vector  OUT_SIZE_2 x signed 48-bit registered neuron results
//
// Storage
//   weight_matrix and bias_vector have no write port and no reset. Their
//   contents are loaded from outside the logic, for example by a memory
//   initialisation file or a hierarchical preload at simulation/elaboration time.
//
// Build option
//   DENSE2_RELU_EN  when defined, negative saturated results are stored as 0.
module dense_layer_2 #(
  parameter int IN_SIZE_2  = 128,
  parameter int OUT_SIZE_2 = 64,
  parameter int WEIGHT_W   = 16,
  parameter int ACC_W      = 56
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [31:0]  input_vector  [IN_SIZE_2],
  output logic signed [47:0]  output_vector [OUT_SIZE_2]
);

  localparam int IN_W   = 32;
  localparam int OUT_W  = 48;
  localparam int PROD_W = IN_W + WEIGHT_W;
  localparam int I_W    = (IN_SIZE_2 > 1) ? $clog2(IN_SIZE_2) : 1;
  localparam int J_W    = (OUT_SIZE_2 > 1) ? $clog2(OUT_SIZE_2) : 1;
  localparam int A_W    = (OUT_SIZE_2 * IN_SIZE_2 > 1) ? $clog2(OUT_SIZE_2 * IN_SIZE_2) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // NOTE: coefficient storage is a ROM-like array; it is deliberately left out
  // of the reset so it can map onto memory macros and keep its preload.
  logic signed [WEIGHT_W-1:0] weight_matrix [OUT_SIZE_2*IN_SIZE_2];
  logic signed [OUT_W-1:0]    bias_vector   [OUT_SIZE_2];

  state_t                    state, state_next;
  logic        [I_W-1:0]     i;
  logic        [J_W-1:0]     j;
  logic signed [ACC_W-1:0]   acc;

  logic                      last_i, last_j;
  logic        [A_W-1:0]     w_addr;
  logic signed [IN_W-1:0]    cur_in;
  logic signed [WEIGHT_W-1:0] cur_w;
  logic signed [PROD_W-1:0]  in_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, biased;
  logic signed [OUT_W-1:0]   sat, result;

  assign last_i = (i == I_W'(IN_SIZE_2 - 1));
  assign last_j = (j == J_W'(OUT_SIZE_2 - 1));
  assign w_addr = A_W'(j) * A_W'(IN_SIZE_2) + A_W'(i);

  // Signed MAC operands: both factors are widened to the full product
  // width so the multiply is exact (a 32x16 product needs 48 bits).
  assign cur_in   = input_vector[i];
  assign cur_w    = weight_matrix[w_addr];
  assign in_ext   = {{(PROD_W-IN_W){cur_in[IN_W-1]}}, cur_in};
  assign w_ext    = {{(PROD_W-WEIGHT_W){cur_w[WEIGHT_W-1]}}, cur_w};
  assign prod     = in_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-OUT_W){bias_vector[j][OUT_W-1]}}, bias_vector[j]};
  assign biased   = acc + bias_ext;

  // The biased sum fits OUT_W bits only when every bit above the 48-bit sign
  // bit matches that sign bit. Otherwise, clamp to the extreme of the sign.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sat    = biased[OUT_W-1:0];
    result = '0;
    if (biased[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){biased[ACC_W-1]}}) begin
      sat = biased[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
    end
`ifdef DENSE2_RELU_EN
    result = sat[OUT_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: IDLE lasts exactly one cycle after reset release, then
  // MAC/WRITE alternate forever.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = MAC;
      MAC:     if (last_i) state_next = WRITE;
      WRITE:   state_next = MAC;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: indices, accumulator and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i   <= '0;
      j   <= '0;
      acc <= '0;
      for (int k = 0; k < OUT_SIZE_2; k++) output_vector[k] <= '0;
    end else begin
      case (state)
        MAC: begin
          acc <= acc + prod_ext;
          i   <= i + 1'b1;
        end
        WRITE: begin
          output_vector[j] <= result;
          acc <= '0;
          i   <= '0;
          j   <= last_j ? '0 : j + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_2.sv
// Testbench for dense_layer_2. It preloads the coefficient storage
// hierarchically and checks the registered outputs against constant tables
// and an arithmetic reference model of the layer equation.
module tb_dense_layer_2;

  localparam int IN  = 128;
  localparam int OUT = 64;
  localparam int NEURON_CYC = IN + 1;
  localparam int PASS_CYC   = OUT * NEURON_CYC;         // 8256
  localparam longint MAXV   = 64'sd140737488355327;     //  2^47-1
  localparam longint MINV   = -64'sd140737488355328;    // -2^47

  logic                clk = 1'b0;
  logic                rst;
  logic signed [31:0]  in_tb  [IN];
  logic signed [47:0]  out_v  [OUT];

  logic signed [15:0]  w_tb [OUT*IN];
  logic signed [47:0]  b_tb [OUT];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rel    = 0;
  int upd_cyc [OUT];
  logic signed [47:0] prev [OUT];

  typedef struct {
    string              name;
    logic signed [31:0] in_val;
    logic signed [15:0] w_val;
    logic signed [47:0] b_val;
    logic signed [47:0] exp_raw;   // saturated result before the optional ReLU
  } vec_t;

  vec_t vecs [4];

  dense_layer_2 dut (
    .clk           (clk),
    .rst           (rst),
    .input_vector  (in_tb),
    .output_vector (out_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of the most recent change of each output, sampled
  // just after the edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < OUT; k++) begin
      if (out_v[k] !== prev[k]) begin
        prev[k]    = out_v[k];
        upd_cyc[k] = cyc;
      end
    end
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [47:0] relu(input logic signed [47:0] v);
`ifdef DENSE2_RELU_EN
    return (v < 0) ? 48'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: plain 64-bit arithmetic of the layer equation, then clamp.
  function automatic logic signed [47:0] model(input int j);
    longint s;
    s = longint'(b_tb[j]);
    for (int i = 0; i < IN; i++) s += longint'(in_tb[i]) * longint'(w_tb[j*IN+i]);
    if (s > MAXV) s = MAXV;
    else if (s < MINV) s = MINV;
    return relu(48'(s));
  endfunction

  task automatic push_storage();
    for (int k = 0; k < OUT*IN; k++) dut.weight_matrix[k] = w_tb[k];
    for (int k = 0; k < OUT; k++)    dut.bias_vector[k]   = b_tb[k];
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reset, preload, release; outputs are complete one pass + 1 cycle later.
  task automatic reset_load_release();
    @(negedge clk);
    rst = 1'b0;
    push_storage();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rel = cyc;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < OUT; k++) check($sformatf("%s[%0d]", tag, k), out_v[k], model(k));
  endtask

  initial begin
    int ok;
    rst = 1'b0;
    for (int k = 0; k < OUT; k++) prev[k] = 'x;

    vecs[0] = '{"bias_neg",   -32'sd2,       16'sd3,  48'sd1000,        48'sd232};
    vecs[1] = '{"neg_nobias", -32'sd2,       16'sd3,  48'sd0,          -48'sd768};
    vecs[2] = '{"sat_pos",    32'h7FFF_FFFF, 16'h7FFF, 48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF};
    vecs[3] = '{"sat_neg",    32'h7FFF_FFFF, 16'h8000, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000};

    // ---- Reset for 100 cycles with identity-like stimulus loaded ----
    for (int i = 0; i < IN; i++) in_tb[i] = i + 1;
    for (int k = 0; k < OUT*IN; k++) w_tb[k] = ((k % IN) == (k / IN)) ? 16'sd1 : 16'sd0;
    for (int k = 0; k < OUT; k++) b_tb[k] = '0;
    push_storage();
    repeat (100) @(negedge clk);
    ok = 0;
    for (int k = 0; k < OUT; k++) if (out_v[k] === 48'sd0) ok++;
    check("reset_outputs_zero", ok, OUT);
    rst = 1'b1;
    rel = cyc;

    // ---- Identity pass and write timing ----
    wait_until(rel + 1 + PASS_CYC);
    check("first_update_latency", upd_cyc[0] - rel, 1 + NEURON_CYC);
    ok = 0;
    for (int k = 1; k < OUT; k++) if (upd_cyc[k] - upd_cyc[k-1] == NEURON_CYC) ok++;
    check("update_spacing", ok, OUT - 1);
    for (int k = 0; k < OUT; k++) check($sformatf("identity[%0d]", k), out_v[k], 48'(k + 1));

    // Neuron 0 of the second pass starts accumulating on the next edge.
    in_tb[0] = 32'sd100;
    wait_until(rel + 1 + PASS_CYC + NEURON_CYC + 2);
    check("wrap_spacing", upd_cyc[0] - upd_cyc[OUT-1], NEURON_CYC);
    check("wrap_value", out_v[0], 48'sd100);

    // ---- Table of uniform-valued vectors (bias, negatives, saturation) ----
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < IN; i++) in_tb[i] = vecs[v].in_val;
      for (int k = 0; k < OUT*IN; k++) w_tb[k] = vecs[v].w_val;
      for (int k = 0; k < OUT; k++) b_tb[k] = vecs[v].b_val;
      reset_load_release();
      wait_until(rel + 2 + PASS_CYC);
      for (int k = 0; k < OUT; k++)
        check($sformatf("%s[%0d]", vecs[v].name, k), out_v[k], relu(vecs[v].exp_raw));
    end

    // ---- Randomized data against the reference model ----
    for (int i = 0; i < IN; i++) in_tb[i] = 32'(signed'(24'($urandom)));
    for (int k = 0; k < OUT*IN; k++) w_tb[k] = 16'($urandom);
    for (int k = 0; k < OUT; k++) b_tb[k] = 48'({$urandom, $urandom});
    b_tb[1] = 48'h7FFF_FFFF_FFFF;   // push a couple of neurons towards the rails
    b_tb[2] = 48'h8000_0000_0000;
    reset_load_release();
    wait_until(rel + 2 + PASS_CYC);
    check_all("random");

    // ---- Mid-operation input change, then 1-cycle reset in neuron 30 ----
    wait_until(rel + 1 + 15 * NEURON_CYC + 40);
    for (int i = 0; i < IN; i++) in_tb[i] = 32'(signed'(20'($urandom)));
    wait_until(rel + 1 + 30 * NEURON_CYC + 60);
    rst = 1'b0;
    #1;
    ok = 0;
    for (int k = 0; k < OUT; k++) if (out_v[k] === 48'sd0) ok++;
    check("midpass_reset_clears", ok, OUT);
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    wait_until(rel + 2 + PASS_CYC);
    check_all("after_midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
